// File: rtl/lcd_write_ctrl_if.sv
// Upstream request channel and LCD pin bundle for lcd_write_ctrl.
// The master side drives write requests; the slave side is the controller.
interface lcd_write_ctrl_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;
  logic       lcd_rst;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst
  );
endinterface

// File: rtl/lcd_write_ctrl.sv
// Write-only parallel LCD controller: drives the LCD reset pulse and power-up
// wait, then turns each accepted byte into a setup / enable-pulse / hold
// sequence on the LCD pins. All outputs come straight from flops, computed
// from the next state so they line up with the state register.
module lcd_write_ctrl #(
  parameter int RST_CYC  = 4,
  parameter int INIT_CYC = 16,
  parameter int T_SETUP  = 2,
  parameter int T_PULSE  = 4,
  parameter int T_HOLD   = 2
) (
  input  logic            clk,
  input  logic            rst,
  lcd_write_ctrl_if.slave bus
);

  // Counter wide enough for the longest phase
  localparam int MAX_A   = (RST_CYC > INIT_CYC) ? RST_CYC : INIT_CYC;
  localparam int MAX_B   = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > T_HOLD) ? MAX_C : T_HOLD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Terminal counts: a phase of N cycles ends when the counter reads N-1
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

  localparam logic [2:0] S_RST_HOLD  = 3'd0;
  localparam logic [2:0] S_INIT_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_SETUP     = 3'd3;
  localparam logic [2:0] S_PULSE     = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rs_reg, rs_next;
  logic [7:0]       data_reg, data_next;
  logic             lcd_rst_reg, lcd_en_reg, lcd_rs_reg;
  logic [7:0]       lcd_db_reg;
  logic             in_ready_reg, busy_reg;
  logic             active_next;

  // Next-state, phase counter and request latch; counter restarts on every state entry
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    rs_next    = rs_reg;
    data_next  = data_reg;
    case (state_reg)
      S_RST_HOLD: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_INIT_WAIT;
          cnt_next   = '0;
        end
      end
      S_INIT_WAIT: begin
        if (cnt_reg == INIT_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_IDLE: begin
        cnt_next = '0;
        if (bus.in_valid && in_ready_reg) begin
          state_next = S_SETUP;
          rs_next    = bus.in_rs;
          data_next  = bus.in_data;
        end
      end
      S_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end
      end
      S_PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_RST_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  // The bus carries the latched byte only while a write is on the pins
  assign active_next = (state_next == S_SETUP) || (state_next == S_PULSE) ||
                       (state_next == S_HOLD);

  // State, latch and registered pin outputs; reset restarts the power-up sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RST_HOLD;
      cnt_reg      <= '0;
      rs_reg       <= 1'b0;
      data_reg     <= 8'h00;
      lcd_rst_reg  <= 1'b1;
      lcd_en_reg   <= 1'b0;
      lcd_rs_reg   <= 1'b0;
      lcd_db_reg   <= 8'h00;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rs_reg       <= rs_next;
      data_reg     <= data_next;
      lcd_rst_reg  <= (state_next == S_RST_HOLD);
      lcd_en_reg   <= (state_next == S_PULSE);
      lcd_rs_reg   <= active_next & rs_next;
      lcd_db_reg   <= active_next ? data_next : 8'h00;
      in_ready_reg <= (state_next == S_IDLE);
      busy_reg     <= (state_next != S_IDLE);
    end
  end

  assign bus.lcd_rst  = lcd_rst_reg;
  assign bus.lcd_en   = lcd_en_reg;
  assign bus.lcd_rs   = lcd_rs_reg;
  assign bus.lcd_db   = lcd_db_reg;
  assign bus.lcd_rw   = 1'b0;
  assign bus.in_ready = in_ready_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYC, default 4: cycles lcd_rst is held high after reset release.
REQ-002 The block SHALL have parameter INIT_CYC, default 16: power-up wait cycles after lcd_rst falls, before the first write.
REQ-003 The block SHALL have parameter T_SETUP, default 2: cycles lcd_rs/lcd_db are valid before lcd_en rises.
REQ-004 The block SHALL have parameter T_PULSE, default 4: cycles lcd_en is high.
REQ-005 The block SHALL have parameter T_HOLD, default 2: cycles lcd_rs/lcd_db are held after lcd_en falls.
REQ-006 All timing parameters SHALL be >= 1; counter width SHALL be sized to the largest parameter.
REQ-007 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port in_valid, input, 1: upstream write request.
REQ-010 Port in_rs, input, 1: register select for the request (0 command, 1 data).
REQ-011 Port in_data, input, 8: byte to write.
REQ-012 Port in_ready, output, 1: request accepted on a cycle where in_valid and in_ready are both high.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port lcd_en, output, 1: LCD enable strobe.
REQ-015 Port lcd_rs, output, 1: LCD register select.
REQ-016 Port lcd_rw, output, 1: tied 0 (write only).
REQ-017 Port lcd_db, output, 8: LCD data bus.
REQ-018 Port lcd_rst, output, 1: LCD reset, active-high.

Function
REQ-019 The FSM SHALL have states RST_HOLD, INIT_WAIT, IDLE, SETUP, PULSE, HOLD; every output SHALL be registered.
REQ-020 In RST_HOLD the block SHALL drive lcd_rst=1 for RST_CYC cycles, then go to INIT_WAIT.
REQ-021 In INIT_WAIT the block SHALL drive lcd_rst=0 for INIT_CYC cycles, then go to IDLE.
REQ-022 in_ready SHALL be high only in IDLE; in_valid SHALL be ignored in all other states, and no request SHALL be queued.
REQ-023 On acceptance the block SHALL latch in_rs/in_data and enter SETUP on the next cycle.
REQ-024 In SETUP, lcd_db and lcd_rs SHALL equal the latched values and lcd_en SHALL be 0, for T_SETUP cycles.
REQ-025 In PULSE, lcd_en SHALL be 1 for T_PULSE cycles, with lcd_db and lcd_rs unchanged.
REQ-026 In HOLD, lcd_en SHALL be 0 for T_HOLD cycles, with lcd_db and lcd_rs unchanged; the FSM SHALL then return to IDLE.
REQ-027 In IDLE, RST_HOLD and INIT_WAIT, lcd_en, lcd_rs and lcd_db SHALL be 0.
REQ-028 Write throughput: with in_valid held high, successive acceptances SHALL be spaced T_SETUP+T_PULSE+T_HOLD+1 cycles apart (one IDLE cycle per write).
REQ-029 Changes on in_data/in_rs after acceptance SHALL NOT affect the write in progress.
REQ-030 lcd_en SHALL never be high while lcd_db or lcd_rs changes.
REQ-031 The state counter SHALL reload on every state entry; no counter wrap SHALL be visible on any output.

Reset
REQ-032 While rst=1: state=RST_HOLD with counter cleared, lcd_rst=1, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_db=0, in_ready=0, busy=1.
REQ-033 rst asserted in any state, including mid-PULSE, SHALL take effect at the next edge: lcd_en=0, the write in progress is abandoned, and the full RST_HOLD/INIT_WAIT sequence restarts.

Verification
REQ-034 Power-up: deassert rst -> lcd_rst=1 for 4 cycles, then 0; in_ready rises exactly 4+16 cycles after rst release.
REQ-035 Single write in_rs=1, in_data=0x37 -> lcd_db=0x37 and lcd_rs=1 for 8 cycles; lcd_en high only in cycles 3-6 of that window; then all return to 0 and in_ready=1.
REQ-036 Back-to-back: in_valid held high with 0x0A then 0x45 -> acceptances exactly 9 cycles apart; second write unaffected by in_data changing during the first.
REQ-037 Request in INIT_WAIT: in_valid=1 during INIT_WAIT -> no lcd_en activity until IDLE, then accepted on the first IDLE cycle.
REQ-038 Reset mid-PULSE: rst=1 while lcd_en=1 -> next cycle lcd_en=0, lcd_db=0, lcd_rst=1; the init sequence repeats.
REQ-039 Parameter sweep: T_SETUP=T_PULSE=T_HOLD=1 -> a write spans 3 cycles and acceptances are 4 cycles apart.
